multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle successor to the single-cycle opcode decoder: sequences each instruction through
//  FETCH/DECODE/EXEC/MEM/WB states and issues phase-qualified control strobes to the datapath.
//  Waits on a memory ready/valid handshake with a bounded-wait timeout, and latches halt.
//  Sits between instruction register and datapath muxes/register file/data memory.
// PARAMETERS
//  OP_W        4    opcode width; upper OP_W-4 bits must be zero for a defined opcode
//  MEM_TIMEOUT 15   max cycles in MEM waiting for mem_ready before fault (1..255)
//  TO_W        8    width of the wait counter; MEM_TIMEOUT < 2**TO_W
// PORTS
//  clk        in  1     rising-edge clock
//  rst_n      in  1     asynchronous active-low reset
//  start      in  1     leave IDLE and begin fetching
//  ir_valid   in  1     instruction memory returned a word this cycle
//  format     in  1     0 = res/immediate format, 1 = register format
//  opcode     in  OP_W  opcode field of latched instruction
//  sign       in  1     cp direction: 1 = cpout, 0 = cpin
//  mem_ready  in  1     data memory completed the pending read/write
//  ir_write   out 1     latch instruction register (FETCH, when ir_valid)
//  pc_write   out 1     advance PC (one pulse per retired instruction)
//  mem_read   out 1     data memory read request, held through MEM
//  mem_write  out 1     data memory write request, held through MEM
//  write_src  out 2     11 ALU, 00 MEM, 01 IMM, 10 RES; 00 when reg_write=0
//  reg_write  out 1     register file write enable (WB only)
//  cpin/cpout out 1     copy-in / copy-out strobes (WB only)
//  branch     out 1     branch qualifier (EXEC only)
//  jump       out 1     jump qualifier (EXEC only)
//  busy       out 1     state != IDLE and != HALT
//  halted     out 1     sticky: halt opcode retired
//  fault      out 1     sticky: memory timeout or undefined opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, every output 0, wait counter 0, sticky flags cleared.
//  All outputs are registered-state Moore decodes; no output depends combinationally on inputs
//  except ir_write (=FETCH & ir_valid).
//  IDLE -> FETCH on start. FETCH waits for ir_valid -> DECODE. DECODE (1 cycle) -> EXEC.
//  EXEC (1 cycle): branch/jump asserted here; opcode decode registered into class regs.
//   load/store/epar -> MEM; branch/jump -> FETCH w/ pc_write; halt -> HALT;
//   add/cp/format0/default -> WB. Undefined opcode (upper bits nonzero) -> HALT with fault=1.
//  MEM: mem_read (load, epar) or mem_write (store) held high; counter increments each cycle.
//   mem_ready -> WB (load/epar) or FETCH w/ pc_write (store); counter cleared.
//   counter reaches MEM_TIMEOUT without mem_ready -> HALT, fault=1, request dropped.
//   mem_ready in the same cycle the counter hits MEM_TIMEOUT: ready wins, no fault.
//  WB (1 cycle): reg_write=1 except cp; write_src: format0/default IMM, add/epar ALU,
//   load MEM; cp asserts cpout (sign=1) or cpin (sign=0) with reg_write=0. pc_write=1; -> FETCH.
//  HALT: terminal; halted=1 if entered via halt opcode; only rst_n exits. start ignored.
//  Minimum latency: ALU op 4 cycles (FETCH w/ ir_valid, DECODE, EXEC, WB); load 5 + wait.
//  opcode/format/sign sampled only in DECODE and held internally; later input changes ignored.
//  rst_n assertion mid-MEM drops mem_read/mem_write asynchronously.
// STRUCTURE
//  Package ctrl_pkg: opcode constants (add 0000, load 0001, store 0010, jump 0011,
//   branch 0100, epar 0101, cp 0111, shift 1010, halt 1011), write_src encodings, state enum.
//  One sub-module: ctrl_wait_timer (load/clear/increment counter, expired flag, TO_W wide).
// TESTING
//  1 add, ir_valid on 1st FETCH cycle -> reg_write=1, write_src=11 on cycle 4, pc_write same cycle.
//  2 load, mem_ready after 3 MEM cycles -> mem_read high 3 cycles, WB write_src=00, reg_write=1.
//  3 store, mem_ready never -> after 15 MEM cycles state HALT, fault=1, mem_write=0.
//  4 cp sign=1 then sign=0 -> single cpout then cpin pulse in WB, reg_write=0 both.
//  5 halt opcode -> halted=1, busy=0; start pulses thereafter ignored; rst_n=0 clears all.
//  6 rst_n low mid-MEM of load -> mem_read falls immediately, state IDLE, outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, write-back source codes,
// sequencer states and the instruction classes the decoder reduces opcodes to.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_JUMP   = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_EPAR   = 4'b0101;
  localparam logic [3:0] OP_CP     = 4'b0111;
  localparam logic [3:0] OP_SHIFT  = 4'b1010;
  localparam logic [3:0] OP_HALT   = 4'b1011;

  localparam logic [1:0] WS_MEM = 2'b00;
  localparam logic [1:0] WS_IMM = 2'b01;
  localparam logic [1:0] WS_RES = 2'b10;
  localparam logic [1:0] WS_ALU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_IMM, CL_REG, CL_ADD, CL_LOAD, CL_STORE, CL_JUMP,
    CL_BRANCH, CL_EPAR, CL_CP, CL_HALT, CL_UNDEF
  } class_e;

  // Ungrouped opcodes (shift and the spare codes) are plain write-back ops; register
  // format takes its result from the ALU, res/immediate format from the immediate.
  function automatic class_e decode_op(input logic [3:0] op, input logic fmt,
                                       input logic upper_nz);
    class_e cls;
    cls = fmt ? CL_REG : CL_IMM;
    if (upper_nz) begin
      cls = CL_UNDEF;
    end else begin
      case (op)
        OP_ADD:    cls = CL_ADD;
        OP_LOAD:   cls = CL_LOAD;
        OP_STORE:  cls = CL_STORE;
        OP_JUMP:   cls = CL_JUMP;
        OP_BRANCH: cls = CL_BRANCH;
        OP_EPAR:   cls = CL_EPAR;
        OP_CP:     cls = CL_CP;
        OP_HALT:   cls = CL_HALT;
        default:   ;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Wait counter for the MEM phase: clears outside MEM, counts MEM cycles, and flags the
// cycle that is the LIMIT-th one spent waiting.
module ctrl_wait_timer #(
  parameter int TO_W  = 8,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + TO_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired_o = (count_q == TO_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with phase-qualified
// datapath strobes, bounded memory wait, and sticky halt/fault flags.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            ir_valid,
  input  logic            format,
  input  logic [OP_W-1:0] opcode,
  input  logic            sign,
  input  logic            mem_ready,
  output logic            ir_write,
  output logic            pc_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      write_src,
  output logic            reg_write,
  output logic            cpin,
  output logic            cpout,
  output logic            branch,
  output logic            jump,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  state_e          state_q, state_d;
  class_e          class_q, dec_class;
  logic [OP_W-1:0] opcode_q;
  logic            format_q, sign_q;
  logic            store_done_q, store_done_d;
  logic            halted_q, halted_d, fault_q, fault_d;
  logic            upper_nz, in_mem, timer_expired;

  assign upper_nz  = (opcode_q >> 4) != '0;
  assign dec_class = decode_op(opcode_q[3:0], format_q, upper_nz);
  assign in_mem    = (state_q == S_MEM);

  ctrl_wait_timer #(.TO_W(TO_W), .LIMIT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!in_mem),
    .inc_i     (in_mem),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (ir_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (dec_class)
          CL_LOAD, CL_STORE, CL_EPAR: state_d = S_MEM;
          CL_JUMP, CL_BRANCH:         state_d = S_FETCH;
          CL_HALT, CL_UNDEF:          state_d = S_HALT;
          default:                    state_d = S_WB;
        endcase
      end
      // A ready arriving on the final allowed cycle still completes the access.
      S_MEM: begin
        if (mem_ready)          state_d = (class_q == CL_STORE) ? S_FETCH : S_WB;
        else if (timer_expired) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    store_done_d = in_mem && mem_ready && (class_q == CL_STORE);
    halted_d     = halted_q || (state_q == S_EXEC && dec_class == CL_HALT);
    fault_d      = fault_q || (state_q == S_EXEC && dec_class == CL_UNDEF)
                           || (in_mem && !mem_ready && timer_expired);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q     <= '0;
      format_q     <= 1'b0;
      sign_q       <= 1'b0;
      class_q      <= CL_IMM;
      store_done_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        format_q <= format;
        sign_q   <= sign;
      end
      if (state_q == S_EXEC) class_q <= dec_class;
      store_done_q <= store_done_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    ir_write  = (state_q == S_FETCH) && ir_valid;
    pc_write  = store_done_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    write_src = WS_MEM;
    reg_write = 1'b0;
    cpin      = 1'b0;
    cpout     = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    halted    = halted_q;
    fault     = fault_q;
    case (state_q)
      S_EXEC: begin
        branch   = (dec_class == CL_BRANCH);
        jump     = (dec_class == CL_JUMP);
        pc_write = branch || jump;
      end
      S_MEM: begin
        mem_read  = (class_q == CL_LOAD) || (class_q == CL_EPAR);
        mem_write = (class_q == CL_STORE);
      end
      S_WB: begin
        pc_write = 1'b1;
        if (class_q == CL_CP) begin
          cpout = sign_q;
          cpin  = !sign_q;
        end else begin
          reg_write = 1'b1;
          case (class_q)
            CL_LOAD:                 write_src = WS_MEM;
            CL_ADD, CL_EPAR, CL_REG: write_src = WS_ALU;
            default:                 write_src = WS_IMM;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus queues cycle-stamped expected strobe
// events, a negedge monitor pops and compares them whenever the DUT raises any strobe.
module tb_multicycle_control;

  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] ADD    = 5'b00000;
  localparam logic [OP_W-1:0] LOAD   = 5'b00001;
  localparam logic [OP_W-1:0] STORE  = 5'b00010;
  localparam logic [OP_W-1:0] JUMP   = 5'b00011;
  localparam logic [OP_W-1:0] BRANCH = 5'b00100;
  localparam logic [OP_W-1:0] EPAR   = 5'b00101;
  localparam logic [OP_W-1:0] CP     = 5'b00111;
  localparam logic [OP_W-1:0] SHIFT  = 5'b01010;
  localparam logic [OP_W-1:0] HALT   = 5'b01011;
  localparam logic [OP_W-1:0] UNDEF  = 5'b10000;

  logic clk = 1'b0;
  logic rst_n, start, ir_valid, format, sign, mem_ready;
  logic [OP_W-1:0] opcode;
  logic ir_write, pc_write, mem_read, mem_write, reg_write, cpin, cpout;
  logic branch, jump, busy, halted, fault;
  logic [1:0] write_src;

  multicycle_control #(.OP_W(OP_W), .MEM_TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir_valid(ir_valid), .format(format),
    .opcode(opcode), .sign(sign), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
    .write_src(write_src), .reg_write(reg_write), .cpin(cpin), .cpout(cpout),
    .branch(branch), .jump(jump), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       pcw, rw;
    logic [1:0] ws;
    logic       cpi, cpo, br, jp, mr, mw;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_exp, mon_act;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int c, input logic pcw, input logic rw,
                                  input logic [1:0] ws, input logic cpi, input logic cpo,
                                  input logic br, input logic jp, input logic mr,
                                  input logic mw);
    ev_t e;
    e = '{c, pcw, rw, ws, cpi, cpo, br, jp, mr, mw};
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (pc_write || reg_write || cpin || cpout || branch || jump ||
                  mem_read || mem_write || write_src != 2'b00)) begin
      mon_act = '{cyc, pc_write, reg_write, write_src, cpin, cpout, branch, jump,
                  mem_read, mem_write};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check($sformatf("event_cyc%0d", mon_exp.cyc), mon_act, mon_exp);
      end
    end
  end

  function automatic logic [13:0] all_outs();
    return {ir_write, pc_write, mem_read, mem_write, write_src, reg_write, cpin, cpout,
            branch, jump, busy, halted, fault};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents an instruction in the current FETCH cycle f, returns in EXEC (f+2) with the
  // instruction fields scrambled so the held copy must be what the DUT uses.
  task automatic issue(input logic [OP_W-1:0] op, input logic fmt, input logic sgn,
                       output int f);
    f        = cyc;
    opcode   = op;
    format   = fmt;
    sign     = sgn;
    ir_valid = 1'b1;
    #1 check("ir_write", ir_write, 1'b1);
    tick();
    ir_valid = 1'b0;
    tick();
    opcode = op ^ OP_W'(4'hF);
    format = ~fmt;
    sign   = ~sgn;
  endtask

  task automatic mem_phase(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == n) mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f;
    rst_n = 1'b0; start = 1'b0; ir_valid = 1'b0; format = 1'b0; sign = 1'b0;
    mem_ready = 1'b0; opcode = '0;
    #3 check("reset_outputs", all_outs(), 14'h0);
    #9 rst_n = 1'b1;
    tick();
    check("idle_not_busy", busy, 1'b0);

    start_run();
    check("fetch_busy", busy, 1'b1);

    issue(ADD, 1'b1, 1'b0, f);
    push_ev(f + 3, 1, 1, 2'b11, 0, 0, 0, 0, 0, 0);
    tick(2);

    issue(LOAD, 1'b0, 1'b0, f);
    for (int i = 3; i <= 5; i++) push_ev(f + i, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    push_ev(f + 6, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    mem_phase(3);
    tick();

    issue(EPAR, 1'b1, 1'b0, f);
    push_ev(f + 3, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    push_ev(f + 4, 1, 1, 2'b11, 0, 0, 0, 0, 0, 0);
    mem_phase(1);
    tick();

    issue(STORE, 1'b0, 1'b0, f);
    push_ev(f + 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    push_ev(f + 4, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    mem_phase(1);

    issue(JUMP, 1'b0, 1'b0, f);
    push_ev(f + 2, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    tick();

    issue(BRANCH, 1'b1, 1'b1, f);
    push_ev(f + 2, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    tick();

    issue(SHIFT, 1'b0, 1'b0, f);
    push_ev(f + 3, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0);
    tick(2);

    issue(CP, 1'b0, 1'b1, f);
    push_ev(f + 3, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    tick(2);

    issue(CP, 1'b0, 1'b0, f);
    push_ev(f + 3, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0);
    tick(2);

    issue(LOAD, 1'b0, 1'b0, f);
    for (int i = 3; i <= 17; i++) push_ev(f + i, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    push_ev(f + 18, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    mem_phase(15);
    check("ready_on_last_cycle_no_fault", fault, 1'b0);
    tick();

    issue(STORE, 1'b0, 1'b0, f);
    for (int i = 3; i <= 17; i++) push_ev(f + i, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick(16);
    check("timeout_fault", fault, 1'b1);
    check("timeout_write_dropped", mem_write, 1'b0);
    check("timeout_not_busy", busy, 1'b0);
    check("timeout_not_halted", halted, 1'b0);

    rst_n = 1'b0;
    #1 check("reset_clears_fault", all_outs(), 14'h0);
    #1 rst_n = 1'b1;
    start_run();
    issue(LOAD, 1'b0, 1'b0, f);
    push_ev(f + 3, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    push_ev(f + 4, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    tick(2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_mem_read", mem_read, 1'b0);
    check("reset_mid_mem_outputs", all_outs(), 14'h0);
    #1 rst_n = 1'b1;
    tick(2);
    check("after_reset_idle", busy, 1'b0);

    start_run();
    issue(HALT, 1'b0, 1'b0, f);
    tick();
    check("halt_halted", halted, 1'b1);
    check("halt_not_busy", busy, 1'b0);
    check("halt_no_fault", fault, 1'b0);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    ir_valid = 1'b1;
    #1 check("halt_ignores_start", {busy, ir_write, halted}, 3'b001);
    ir_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("reset_clears_halt", all_outs(), 14'h0);
    #1 rst_n = 1'b1;

    start_run();
    issue(UNDEF, 1'b0, 1'b0, f);
    tick();
    check("undef_fault", {fault, halted, busy}, 3'b100);

    tick(3);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
